// File: rtl/rs232_frame_rx_if.sv
// rs232_frame_rx_if: byte-in / frame-out bundle for the RS232 frame receiver
interface rs232_frame_rx_if;
  logic [7:0] RX_DATA;
  logic RX_VALID;
  logic [7:0] FRM_CMD;
  logic [7:0] FRM_LEN;
  logic [31:0] FRM_DATA;
  logic FRM_VALID;
  logic FRM_ERR;
  logic [1:0] ERR_CODE;
  logic BUSY;
  modport master (
    output RX_DATA, RX_VALID,
    input FRM_CMD, FRM_LEN, FRM_DATA, FRM_VALID, FRM_ERR, ERR_CODE, BUSY
  );
  modport slave (
    input RX_DATA, RX_VALID,
    output FRM_CMD, FRM_LEN, FRM_DATA, FRM_VALID, FRM_ERR, ERR_CODE, BUSY
  );
endinterface

// File: rtl/rs232_frame_rx.sv
// rs232_frame_rx: parses FF/CMD/LEN/payload frames from a UART byte stream
module rs232_frame_rx #(
  parameter int MAX_LEN = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input logic CLOCK_50,
  input logic RESET_N,
  rs232_frame_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, LEN, DATA} state_t;
  state_t state, nxt;
  logic [1:0] cnt;
  logic [2:0] len_q;
  logic [7:0] cmd_q;
  logic [31:0] data_q, data_nxt;
  logic [31:0] tmo;
  logic tmo_hit, done, len_err, last;
  assign bus.BUSY = state != IDLE;
  assign tmo_hit = state != IDLE && !bus.RX_VALID && tmo == 32'(TIMEOUT_CYC - 1);
  assign last = {1'b0, cnt} + 3'd1 == len_q;
  always_comb begin
    nxt = state;
    done = 1'b0;
    len_err = 1'b0;
    data_nxt = data_q;
    data_nxt[{cnt, 3'b000} +: 8] = bus.RX_DATA;
    if (tmo_hit)
      nxt = IDLE;
    else if (bus.RX_VALID)
      unique case (state)
        IDLE: nxt = bus.RX_DATA == 8'hFF ? CMD : IDLE;
        CMD: nxt = LEN;
        LEN: begin
          done = bus.RX_DATA == 8'd0;
          len_err = bus.RX_DATA > 8'(MAX_LEN);
          nxt = done || len_err ? IDLE : DATA;
        end
        DATA: begin
          done = last;
          nxt = last ? IDLE : DATA;
        end
      endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      cmd_q <= '0;
      data_q <= '0;
      tmo <= '0;
      bus.FRM_CMD <= '0;
      bus.FRM_LEN <= '0;
      bus.FRM_DATA <= '0;
      bus.FRM_VALID <= 1'b0;
      bus.FRM_ERR <= 1'b0;
      bus.ERR_CODE <= '0;
    end else begin
      state <= nxt;
      tmo <= bus.RX_VALID || state == IDLE ? '0 : tmo + 32'd1;
      bus.FRM_VALID <= done;
      bus.FRM_ERR <= len_err || tmo_hit;
      if (len_err || tmo_hit)
        bus.ERR_CODE <= tmo_hit ? 2'd2 : 2'd1;
      if (bus.RX_VALID)
        unique case (state)
          IDLE: begin
            cnt <= '0;
            data_q <= '0;
          end
          CMD: cmd_q <= bus.RX_DATA;
          LEN: len_q <= bus.RX_DATA[2:0];
          DATA: begin
            data_q <= data_nxt;
            cnt <= cnt + 2'd1;
          end
        endcase
      // a zero-length frame completes on the LEN byte itself, before len_q is loaded
      if (done) begin
        bus.FRM_CMD <= cmd_q;
        bus.FRM_LEN <= state == LEN ? bus.RX_DATA : {5'd0, len_q};
        bus.FRM_DATA <= state == LEN ? '0 : data_nxt;
      end
    end
  end
endmodule

// File: tb/tb_rs232_frame_rx.sv
// tb_rs232_frame_rx: directed scenario bench for rs232_frame_rx
module tb_rs232_frame_rx;
  localparam int T = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0, nv = 0, ne = 0;
  rs232_frame_rx_if bus();
  rs232_frame_rx #(.MAX_LEN(4), .TIMEOUT_CYC(T)) dut (.CLOCK_50(clk), .RESET_N(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.FRM_VALID) nv++;
    if (bus.FRM_ERR) ne++;
  end
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus.RX_DATA = b;
    bus.RX_VALID = 1'b1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.RX_VALID = 1'b0;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA = 8'h00;
    idle(3);
    total += 7;
    if (bus.FRM_CMD !== 8'h00) begin bad++; $display("FAIL rst_cmd got=%h exp=00", bus.FRM_CMD); end
    if (bus.FRM_LEN !== 8'h00) begin bad++; $display("FAIL rst_len got=%h exp=00", bus.FRM_LEN); end
    if (bus.FRM_DATA !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.FRM_DATA); end
    if (bus.FRM_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.FRM_VALID); end
    if (bus.FRM_ERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.FRM_ERR); end
    if (bus.ERR_CODE !== 2'd0) begin bad++; $display("FAIL rst_code got=%0d exp=0", bus.ERR_CODE); end
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.BUSY); end
    rst_n = 1'b1;
    idle(1);
  endtask
  task automatic test_single;
    nv = 0; ne = 0;
    put(8'hFF); put(8'h00);
    total++;
    if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.BUSY); end
    put(8'h01); put(8'h1E);
    idle(3);
    total += 5;
    if (nv !== 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", nv); end
    if (bus.FRM_CMD !== 8'h00) begin bad++; $display("FAIL single_cmd got=%h exp=00", bus.FRM_CMD); end
    if (bus.FRM_LEN !== 8'h01) begin bad++; $display("FAIL single_len got=%h exp=01", bus.FRM_LEN); end
    if (bus.FRM_DATA !== 32'h0000001E) begin bad++; $display("FAIL single_data got=%h exp=0000001e", bus.FRM_DATA); end
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", bus.BUSY); end
  endtask
  task automatic test_noise_zero_len;
    nv = 0; ne = 0;
    put(8'h12); put(8'h34);
    idle(1);
    total++;
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL noise_busy got=%b exp=0", bus.BUSY); end
    put(8'hFF); put(8'h02); put(8'h00);
    total++;
    if (bus.FRM_VALID !== 1'b0) begin bad++; $display("FAIL zlen_early got=%b exp=0", bus.FRM_VALID); end
    idle(1);
    total += 4;
    if (bus.FRM_VALID !== 1'b1) begin bad++; $display("FAIL zlen_valid got=%b exp=1", bus.FRM_VALID); end
    if (bus.FRM_CMD !== 8'h02) begin bad++; $display("FAIL zlen_cmd got=%h exp=02", bus.FRM_CMD); end
    if (bus.FRM_LEN !== 8'h00) begin bad++; $display("FAIL zlen_len got=%h exp=00", bus.FRM_LEN); end
    if (bus.FRM_DATA !== 32'h0) begin bad++; $display("FAIL zlen_data got=%h exp=0", bus.FRM_DATA); end
    idle(2);
    total++;
    if (nv !== 1) begin bad++; $display("FAIL zlen_pulses got=%0d exp=1", nv); end
  endtask
  task automatic test_back_to_back;
    nv = 0; ne = 0;
    put(8'hFF); put(8'h01); put(8'h03); put(8'h45); put(8'h23); put(8'h01);
    put(8'hFF); put(8'h07); put(8'h04); put(8'h11); put(8'hFF); put(8'h33); put(8'h44);
    idle(1);
    total += 3;
    if (bus.FRM_VALID !== 1'b1) begin bad++; $display("FAIL max_valid got=%b exp=1", bus.FRM_VALID); end
    if (bus.FRM_DATA !== 32'h4433FF11) begin bad++; $display("FAIL max_data got=%h exp=4433ff11", bus.FRM_DATA); end
    if (bus.FRM_LEN !== 8'h04) begin bad++; $display("FAIL max_len got=%h exp=04", bus.FRM_LEN); end
    idle(2);
    total++;
    if (nv !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", nv); end
    put(8'hFF); put(8'h01); put(8'h03); put(8'h45); put(8'h23); put(8'h01);
    idle(2);
    total += 3;
    if (bus.FRM_CMD !== 8'h01) begin bad++; $display("FAIL b2b_cmd got=%h exp=01", bus.FRM_CMD); end
    if (bus.FRM_LEN !== 8'h03) begin bad++; $display("FAIL b2b_len got=%h exp=03", bus.FRM_LEN); end
    if (bus.FRM_DATA !== 32'h00012345) begin bad++; $display("FAIL b2b_data got=%h exp=00012345", bus.FRM_DATA); end
  endtask
  task automatic test_len_overflow;
    nv = 0; ne = 0;
    put(8'hFF); put(8'h05); put(8'h05);
    idle(1);
    total += 3;
    if (bus.FRM_ERR !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", bus.FRM_ERR); end
    if (bus.ERR_CODE !== 2'd1) begin bad++; $display("FAIL ovf_code got=%0d exp=1", bus.ERR_CODE); end
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL ovf_busy got=%b exp=0", bus.BUSY); end
    put(8'hFF); put(8'h09); put(8'h00);
    idle(2);
    total += 6;
    if (nv !== 1) begin bad++; $display("FAIL ovf_pulses got=%0d exp=1", nv); end
    if (ne !== 1) begin bad++; $display("FAIL ovf_errs got=%0d exp=1", ne); end
    if (bus.FRM_CMD !== 8'h09) begin bad++; $display("FAIL ovf_resync got=%h exp=09", bus.FRM_CMD); end
    if (bus.ERR_CODE !== 2'd1) begin bad++; $display("FAIL ovf_hold got=%0d exp=1", bus.ERR_CODE); end
    put(8'hFF); put(8'h05); put(8'h05);
    idle(2);
    if (bus.FRM_CMD !== 8'h09) begin bad++; $display("FAIL ovf_keep_cmd got=%h exp=09", bus.FRM_CMD); end
    if (bus.FRM_DATA !== 32'h0) begin bad++; $display("FAIL ovf_keep_data got=%h exp=0", bus.FRM_DATA); end
  endtask
  task automatic test_timeout;
    int k;
    nv = 0; ne = 0;
    put(8'hFF); put(8'h01); put(8'h02); put(8'hAA);
    k = 0;
    while (k < 4 * T && bus.FRM_ERR !== 1'b1) begin
      idle(1);
      k++;
    end
    total += 5;
    if (k !== T + 1) begin bad++; $display("FAIL tmo_cycles got=%0d exp=%0d", k, T + 1); end
    if (bus.ERR_CODE !== 2'd2) begin bad++; $display("FAIL tmo_code got=%0d exp=2", bus.ERR_CODE); end
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b exp=0", bus.BUSY); end
    if (bus.FRM_DATA !== 32'h0) begin bad++; $display("FAIL tmo_keep got=%h exp=0", bus.FRM_DATA); end
    idle(2);
    if (nv !== 0) begin bad++; $display("FAIL tmo_valid got=%0d exp=0", nv); end
    nv = 0; ne = 0;
    put(8'hFF); put(8'h03); put(8'h02); put(8'hAA);
    idle(T - 1);
    put(8'hBB);
    idle(1);
    total += 3;
    if (bus.FRM_VALID !== 1'b1) begin bad++; $display("FAIL race_valid got=%b exp=1", bus.FRM_VALID); end
    if (bus.FRM_DATA !== 32'h0000BBAA) begin bad++; $display("FAIL race_data got=%h exp=0000bbaa", bus.FRM_DATA); end
    idle(2);
    if (ne !== 0) begin bad++; $display("FAIL race_err got=%0d exp=0", ne); end
  endtask
  task automatic test_reset_mid;
    nv = 0; ne = 0;
    put(8'hFF); put(8'h01); put(8'h02); put(8'hAA);
    @(negedge clk);
    bus.RX_VALID = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.BUSY); end
    put(8'hFF); put(8'h00); put(8'h01); put(8'hFF);
    idle(3);
    total += 3;
    if (bus.FRM_DATA !== 32'h000000FF) begin bad++; $display("FAIL rmid_data got=%h exp=000000ff", bus.FRM_DATA); end
    if (nv !== 1) begin bad++; $display("FAIL rmid_pulses got=%0d exp=1", nv); end
    if (ne !== 0) begin bad++; $display("FAIL rmid_err got=%0d exp=0", ne); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_noise_zero_len;
    test_back_to_back;
    test_len_overflow;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs232_frame_rx.md
RS232_FRAME_RX -- requirements
Module: rs232_frame_rx

Interface
REQ-001 The block SHALL have a parameter MAX_LEN, default 4, giving the maximum payload bytes accepted per frame (1..4).
REQ-002 The block SHALL have a parameter TIMEOUT_CYC, default 500000, giving the maximum CLOCK_50 cycles allowed between bytes inside a frame.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port RX_DATA, input, 8 bits: received UART byte, valid only while RX_VALID=1.
REQ-006 The block SHALL have port RX_VALID, input, 1 bit: one-cycle strobe per received byte.
REQ-007 The block SHALL have port FRM_CMD, output, 8 bits: command byte of the last good frame.
REQ-008 The block SHALL have port FRM_LEN, output, 8 bits: length byte of the last good frame.
REQ-009 The block SHALL have port FRM_DATA, output, 32 bits: payload of the last good frame, little-endian.
REQ-010 The block SHALL have port FRM_VALID, output, 1 bit: one-cycle pulse when a good frame completes.
REQ-011 The block SHALL have port FRM_ERR, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-012 The block SHALL have port ERR_CODE, output, 2 bits: abort cause, 1 = length overflow, 2 = timeout; 0 after reset.
REQ-013 The block SHALL have port BUSY, output, 1 bit: 1 while in any state other than IDLE.

Function
REQ-014 Frame format SHALL be: sync 8'hFF, CMD, LEN, then LEN payload bytes, least significant byte first.
REQ-015 FSM states SHALL be IDLE, CMD, LEN, DATA.
- IDLE -> CMD on RX_VALID with RX_DATA=8'hFF; other bytes are discarded silently.
- CMD -> LEN on any byte, which is captured as the command.
- LEN -> DATA when 0 < RX_DATA <= MAX_LEN.
REQ-016 In LEN with RX_DATA=0, the block SHALL complete the frame immediately with FRM_DATA=0.
REQ-017 In LEN with RX_DATA>MAX_LEN, the block SHALL abort with ERR_CODE=1 and return to IDLE; no payload bytes are consumed.
REQ-018 In DATA, payload byte i (0-based) SHALL be written to bits [8i+7:8i]; unreceived upper bits SHALL read 0.
REQ-019 The block SHALL use a byte counter compared against the latched LEN; on the final byte it SHALL complete and go to IDLE.
REQ-020 Bytes after sync SHALL NOT be interpreted; 8'hFF in CMD, LEN or DATA is ordinary data and does not restart the frame.
REQ-021 Completion latency: FRM_VALID SHALL pulse on the cycle after the clock edge that samples the last byte (LEN byte if LEN=0).
REQ-022 FRM_CMD, FRM_LEN and FRM_DATA SHALL update in the same cycle as FRM_VALID and hold until the next good frame.
REQ-023 FRM_CMD, FRM_LEN and FRM_DATA SHALL NOT be changed by aborted frames.
REQ-024 Working registers SHALL be separate from the output registers.
REQ-025 Timeout: an inter-byte counter SHALL clear on every RX_VALID and count while state != IDLE.
REQ-026 When the timeout counter reaches TIMEOUT_CYC-1, the block SHALL pulse FRM_ERR with ERR_CODE=2 and return to IDLE.
REQ-027 If RX_VALID arrives on the same cycle the timeout fires, the byte SHALL win and no timeout is raised.
REQ-028 ERR_CODE SHALL update in the same cycle as FRM_ERR and hold until the next abort.
REQ-029 FRM_VALID and FRM_ERR SHALL never be asserted in the same cycle.
REQ-030 The block SHALL accept back-to-back RX_VALID strobes on consecutive cycles with no byte lost.
REQ-031 A new sync byte arriving in the cycle after completion or abort SHALL be accepted.

Reset
REQ-032 While RESET_N=0 at a clock edge, the block SHALL go to IDLE, clear counters and working registers, and drive FRM_CMD=0, FRM_LEN=0, FRM_DATA=0, FRM_VALID=0, FRM_ERR=0, ERR_CODE=0 and BUSY=0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame with no FRM_VALID and no FRM_ERR pulse.

Verification
REQ-034 Bytes FF 00 01 1E SHALL give exactly one FRM_VALID pulse with FRM_CMD=00, FRM_LEN=01, FRM_DATA=0000001E.
REQ-035 Bytes FF 01 03 45 23 01, sent back-to-back, SHALL give FRM_CMD=01, FRM_LEN=03, FRM_DATA=00012345.
REQ-036 Bytes 12 34 FF 02 00 SHALL ignore 12 and 34 and give FRM_CMD=02, FRM_LEN=00, FRM_DATA=0, with FRM_VALID one cycle after the 00 byte.
REQ-037 Bytes FF 05 05 SHALL give FRM_ERR with ERR_CODE=1 and BUSY=0; the previous FRM_* values SHALL be retained.
REQ-038 Bytes FF 01 02 AA followed by TIMEOUT_CYC idle cycles SHALL give FRM_ERR with ERR_CODE=2 and no FRM_VALID.
REQ-039 Bytes FF 01 02 AA, then RESET_N=0 for 1 cycle, then FF 00 01 FF SHALL give FRM_DATA=000000FF and no FRM_ERR.
